pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS-style pipeline's instruction-fetch stage. It holds the fetch address and selects the next PC from sequential increment, branch target, jump target or a return-address stack (RAS). It supports pipeline stalls and flags misaligned targets. It feeds PCResult to instruction memory and PCPlus to the IF/ID register.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the fetch-stage controller and pc_sequencer.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  // Next-PC controls
  logic             stall;
  logic             branch;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             call;
  logic             ret;

  // Fetch address and status
  logic [WIDTH-1:0] pc_result;
  logic [WIDTH-1:0] pc_plus;
  logic             ras_empty;
  logic             ras_full;
  logic             misaligned;

  // Controller side: drives controls, observes fetch address and status.
  modport master (
    output stall, branch, branch_target, jump, jump_target, call, ret,
    input  pc_result, pc_plus, ras_empty, ras_full, misaligned
  );

  // Sequencer side.
  modport slave (
    input  stall, branch, branch_target, jump, jump_target, call, ret,
    output pc_result, pc_plus, ras_empty, ras_full, misaligned
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the instruction-fetch stage: sequential, branch,
// jump, call/return via a circular return-address stack, stall and misalign flag.
module pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned INC          = 4,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  // ptr_q is the next slot to write; the top of stack sits one below it.
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] sel;
  logic [PtrW-1:0]  top_idx;
  logic             push, pop, take_target;
  logic             push_en;

  assign pc_plus  = pc_q + WIDTH'(INC);
  assign top_idx  = ptr_q - PtrW'(1);
  assign push_en  = push && !bus.stall;

  // Next-PC source selection by priority: return, call, jump, branch, sequential.
  always_comb begin
    sel         = pc_plus;
    push        = 1'b0;
    pop         = 1'b0;
    take_target = 1'b0;
    if (bus.ret) begin
      take_target = 1'b1;
      if (count_q != '0) begin
        sel = ras_q[top_idx];
        pop = 1'b1;
      end else begin
        sel = bus.jump_target;
      end
    end else if (bus.call) begin
      take_target = 1'b1;
      sel         = bus.jump_target;
      push        = 1'b1;
    end else if (bus.jump) begin
      take_target = 1'b1;
      sel         = bus.jump_target;
    end else if (bus.branch) begin
      take_target = 1'b1;
      sel         = bus.branch_target;
    end
  end

  // Next-state for PC, stack pointer, count and sticky misalign flag.
  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    mis_d   = mis_q;
    if (!bus.stall) begin
      pc_d  = {sel[WIDTH-1:2], 2'b00};
      mis_d = mis_q | (take_target && (sel[1:0] != 2'b00));
      if (push) begin
        ptr_d = ptr_q + PtrW'(1);
        // Saturate: a push when full overwrites the oldest slot.
        if (count_q != CntW'(RAS_DEPTH)) begin
          count_d = count_q + CntW'(1);
        end
      end else if (pop) begin
        ptr_d   = top_idx;
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q    <= WIDTH'(RESET_VECTOR);
      ptr_q   <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end

  // Stack storage; contents are don't-care after reset, so it is not cleared.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push_en) begin
      ras_q[ptr_q] <= pc_plus;
    end
  end

  assign bus.pc_result  = pc_q;
  assign bus.pc_plus    = pc_plus;
  assign bus.ras_empty  = (count_q == '0);
  assign bus.ras_full   = (count_q == CntW'(RAS_DEPTH));
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (32-bit main instance plus an
// 8-bit instance for wrap-around).
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  pc_sequencer_if #(.WIDTH(32)) bus_a ();
  pc_sequencer_if #(.WIDTH(8))  bus_b ();

  pc_sequencer #(.WIDTH(32), .INC(4), .RESET_VECTOR(0), .RAS_DEPTH(4)) u_dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_a)
  );

  pc_sequencer #(.WIDTH(8), .INC(4), .RESET_VECTOR(252), .RAS_DEPTH(4)) u_dut8 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.stall         = 1'b0;
    bus_a.branch        = 1'b0;
    bus_a.branch_target = '0;
    bus_a.jump          = 1'b0;
    bus_a.jump_target   = '0;
    bus_a.call          = 1'b0;
    bus_a.ret           = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    idle_a();
    bus_b.stall         = 1'b0;
    bus_b.branch        = 1'b0;
    bus_b.branch_target = '0;
    bus_b.jump          = 1'b0;
    bus_b.jump_target   = '0;
    bus_b.call          = 1'b0;
    bus_b.ret           = 1'b0;

    // Reset
    reset = 1'b1;
    step();
    check("rst_pc", bus_a.pc_result, 32'h0);
    check("rst_pcplus", bus_a.pc_plus, 32'h4);
    check("rst_empty", {31'b0, bus_a.ras_empty}, 32'h1);
    check("rst_full", {31'b0, bus_a.ras_full}, 32'h0);
    check("rst_mis", {31'b0, bus_a.misaligned}, 32'h0);
    check("w8_rst_pc", {24'b0, bus_b.pc_result}, 32'd252);
    check("w8_pcplus", {24'b0, bus_b.pc_plus}, 32'd0);
    reset = 1'b0;

    // Sequential run; the 8-bit instance wraps on the same edge
    step();
    check("seq1", bus_a.pc_result, 32'h4);
    check("w8_wrap_pc", {24'b0, bus_b.pc_result}, 32'd0);
    check("w8_wrap_mis", {31'b0, bus_b.misaligned}, 32'h0);
    step();
    check("seq2", bus_a.pc_result, 32'h8);
    step();
    check("seq3", bus_a.pc_result, 32'hC);
    step();
    check("seq4", bus_a.pc_result, 32'h10);

    // Stall holds even with a jump request present
    bus_a.stall       = 1'b1;
    bus_a.jump        = 1'b1;
    bus_a.jump_target = 32'h500;
    step();
    check("stall1", bus_a.pc_result, 32'h10);
    step();
    check("stall2", bus_a.pc_result, 32'h10);
    idle_a();
    step();
    check("resume", bus_a.pc_result, 32'h14);

    // Priority: jump over branch, then branch alone
    bus_a.branch        = 1'b1;
    bus_a.branch_target = 32'h100;
    bus_a.jump          = 1'b1;
    bus_a.jump_target   = 32'h200;
    step();
    check("prio_jump", bus_a.pc_result, 32'h200);
    bus_a.jump = 1'b0;
    step();
    check("branch", bus_a.pc_result, 32'h100);
    check("branch_mis", {31'b0, bus_a.misaligned}, 32'h0);

    // Call/return nesting from 0x10
    idle_a();
    bus_a.jump        = 1'b1;
    bus_a.jump_target = 32'h10;
    step();
    check("to_10", bus_a.pc_result, 32'h10);
    idle_a();
    bus_a.call        = 1'b1;
    bus_a.jump_target = 32'h80;
    step();
    check("call1", bus_a.pc_result, 32'h80);
    check("call1_empty", {31'b0, bus_a.ras_empty}, 32'h0);
    bus_a.jump_target = 32'hC0;
    step();
    check("call2", bus_a.pc_result, 32'hC0);
    idle_a();
    bus_a.ret = 1'b1;
    step();
    check("ret1", bus_a.pc_result, 32'h84);
    step();
    check("ret2", bus_a.pc_result, 32'h14);
    check("ret2_empty", {31'b0, bus_a.ras_empty}, 32'h1);

    // Simultaneous call and return: return wins, no push
    idle_a();
    bus_a.call        = 1'b1;
    bus_a.jump_target = 32'h40;
    step();
    check("call_40", bus_a.pc_result, 32'h40);
    bus_a.ret         = 1'b1;
    bus_a.jump_target = 32'h60;
    step();
    check("callret_pc", bus_a.pc_result, 32'h18);
    check("callret_empty", {31'b0, bus_a.ras_empty}, 32'h1);

    // Overflow: five calls push 0x1C, 0x1004, 0x2004, 0x3004, 0x4004
    idle_a();
    bus_a.call = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus_a.jump_target = 32'h1000 * k;
      step();
      check("ovf_call", bus_a.pc_result, 32'h1000 * k);
    end
    check("ovf_full", {31'b0, bus_a.ras_full}, 32'h1);
    idle_a();
    bus_a.ret         = 1'b1;
    bus_a.jump_target = 32'h300;
    for (int k = 4; k >= 1; k--) begin
      step();
      check("ovf_ret", bus_a.pc_result, 32'h1000 * k + 32'h4);
    end
    check("ovf_empty", {31'b0, bus_a.ras_empty}, 32'h1);
    check("ovf_notfull", {31'b0, bus_a.ras_full}, 32'h0);
    step();
    check("underflow", bus_a.pc_result, 32'h300);
    check("underflow_empty", {31'b0, bus_a.ras_empty}, 32'h1);
    check("underflow_mis", {31'b0, bus_a.misaligned}, 32'h0);

    // Misaligned jump, flag sticks through a call
    idle_a();
    bus_a.jump        = 1'b1;
    bus_a.jump_target = 32'h202;
    step();
    check("mis_pc", bus_a.pc_result, 32'h200);
    check("mis_flag", {31'b0, bus_a.misaligned}, 32'h1);
    idle_a();
    bus_a.call        = 1'b1;
    bus_a.jump_target = 32'h400;
    step();
    check("mis_call_pc", bus_a.pc_result, 32'h400);
    check("mis_sticky", {31'b0, bus_a.misaligned}, 32'h1);
    check("mis_call_empty", {31'b0, bus_a.ras_empty}, 32'h0);

    // Reset together with a call discards the push
    bus_a.jump_target = 32'h800;
    reset             = 1'b1;
    step();
    check("rst2_pc", bus_a.pc_result, 32'h0);
    check("rst2_empty", {31'b0, bus_a.ras_empty}, 32'h1);
    check("rst2_mis", {31'b0, bus_a.misaligned}, 32'h0);
    reset = 1'b0;
    idle_a();
    step();
    check("rst2_seq", bus_a.pc_result, 32'h4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
